fsqrt_seq: RTL
==============

// Module: fsqrt_seq
// PURPOSE
//  Iterative single-precision square-root sequencer. Seeds y0 from the sqrt_init table
//  unit, then runs ITERS Newton steps y <- 0.5*(y + x/y). Each step is three ops
//  (DIV, ADD, MUL), issued over a req/gnt/done port to an FPU shared with other requesters.
//  Sits between the instruction issue stage and the shared FPU arbiter.
// PARAMETERS
//  ITERS   2   Newton iterations after the seed (1..7)
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous active-high reset
//  in_valid   in   1   operand valid
//  in_ready   out  1   ready to accept operand (high only in IDLE)
//  in_x       in   32  IEEE-754 single operand
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  out_y      out  32  sqrt(in_x)
//  out_inv    out  1   invalid-operation flag (negative or NaN input)
//  fpu_req    out  1   FPU op request
//  fpu_op     out  2   00 ADD, 01 MUL, 10 DIV
//  fpu_a      out  32  operand a
//  fpu_b      out  32  operand b
//  fpu_gnt    in   1   FPU accepted request this cycle
//  fpu_done   in   1   one-cycle pulse, fpu_res valid
//  fpu_res    in   32  FPU result
// BEHAVIOUR
//  Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
//  Reset values: state IDLE; iteration counter 0; in_ready=1.
//   out_valid=0, out_y=0, out_inv=0.
//   fpu_req=0, fpu_op=0, fpu_a=0, fpu_b=0.
//  Accept: an operand is accepted at edge T when in_valid && in_ready. x is latched.
//  Classification, decided from the latched x at T+1:
//   e==0 (zero or denormal, denormals flushed): DONE, out_y={s,31'b0}, out_inv=0.
//   e==255 and m!=0 (NaN): DONE, out_y=32'h7FC00000, out_inv=1.
//   s==1, nonzero (negative): DONE, out_y=32'h7FC00000, out_inv=1.
//   x==32'h7F800000 (+inf): DONE, out_y=x, out_inv=0.
//   Special cases give out_valid=1 in cycle T+1 and never raise fpu_req.
//  Normal path: SEED registers y=sqrt_init(x), then goes to DIV_REQ.
//  Op sequence per iteration:
//   DIV_REQ  fpu_op=DIV, a=x, b=y; result t
//   ADD_REQ  fpu_op=ADD, a=y, b=t; result t
//   MUL_REQ  fpu_op=MUL, a=t, b=32'h3F000000; result y
//  *_REQ state rules:
//   fpu_req=1; op and operands are registered and held stable until fpu_gnt.
//   On the fpu_req && fpu_gnt edge, go to the matching *_WAIT. fpu_req is 0 in *_WAIT.
//  *_WAIT state rules:
//   On fpu_done, latch fpu_res and advance to the next *_REQ.
//   fpu_done outside *_WAIT is ignored. A done in the same cycle as the gnt is not accepted.
//  After MUL_WAIT completes:
//   If iter==ITERS-1: DONE, out_y=y.
//   Otherwise: iter++ and go to DIV_REQ.
//  DONE: out_valid=1; out_y and out_inv are held stable while out_ready=0.
//   On out_valid && out_ready, go to IDLE: out_valid=0, in_ready=1 next cycle.
//   There is no accept in the same cycle as output retire.
//  Only one operation is in flight; there is no FPU pipelining within the block.
//  Reset mid-operation: the operation is abandoned; fpu_req drops immediately (async).
//   A later stray fpu_done is ignored in IDLE.
//  Latency: normal path = 2 + ITERS*sum over the 3 ops of (gnt wait + done wait + 1) cycles.
//   With gnt immediate and done 3 cycles after gnt, ITERS=2: out_valid at T+2+24.
// TESTING
//  Latency and handshakes: in_x=32'h40800000 (4.0), ITERS=2, gnt immediate, done latency 3
//   -> out_y=32'h40000000, out_inv=0, exactly 6 fpu_req handshakes (DIV,ADD,MUL x2),
//   out_valid at T+26.
//  Zero: in_x=32'h00000000 -> out_y=0 at T+1, fpu_req never asserted.
//   in_x=32'h80000000 -> out_y=32'h80000000.
//  Invalid inputs: in_x=32'hBF800000 (-1.0) -> out_y=32'h7FC00000, out_inv=1 at T+1.
//   in_x=32'h7F800000 -> out_y=32'h7F800000, out_inv=0.
//  Grant stall: fpu_gnt held low 5 cycles during DIV_REQ -> fpu_req, fpu_op=2'b10, fpu_a,
//   fpu_b stable all 5 cycles; stray fpu_done pulses in a REQ state have no effect.
//  Output backpressure: in_x=32'h41100000 (9.0), out_ready low 10 cycles
//   -> out_valid stays 1, out_y=32'h40400000 stable, in_ready=0 until retire.
//  Reset mid-operation: rst asserted in ADD_WAIT -> fpu_req=0 and out_valid=0 at once;
//   after release in_ready=1, a late fpu_done is ignored, the next 4.0 yields 32'h40000000.

Source files
------------

// File: rtl/fsqrt_seq.sv
// fsqrt_seq: iterative single-precision square root. A table seed is refined by Newton
// steps y <- 0.5*(y + x/y), each step issued as DIV, ADD, MUL to a shared FPU.
module fsqrt_seq #(
    parameter int unsigned ITERS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_inv,
    output logic        fpu_req,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_gnt,
    input  logic        fpu_done,
    input  logic [31:0] fpu_res
);
    typedef enum logic [3:0] {
        IDLE, CLASS, SEED, DIV_REQ, DIV_WAIT, ADD_REQ, ADD_WAIT, MUL_REQ, MUL_WAIT, DONE
    } state_t;

    localparam logic [1:0]  OP_ADD = 2'b00;
    localparam logic [1:0]  OP_MUL = 2'b01;
    localparam logic [1:0]  OP_DIV = 2'b10;
    localparam logic [31:0] QNAN   = 32'h7FC00000;
    localparam logic [31:0] HALF   = 32'h3F000000;

    // Seed mantissa (7 MSBs) = sqrt at the lower edge of each 1/16 mantissa bucket,
    // exact for powers of four and for 2.25, so those inputs converge exactly.
    localparam logic [15:0][6:0] EVEN_TBL = {
        7'd50, 7'd47, 7'd44, 7'd41, 7'd38, 7'd35, 7'd32, 7'd29,
        7'd25, 7'd22, 7'd19, 7'd15, 7'd11, 7'd8,  7'd4,  7'd0
    };
    localparam logic [15:0][6:0] ODD_TBL = {
        7'd124, 7'd120, 7'd116, 7'd111, 7'd107, 7'd103, 7'd98, 7'd94,
        7'd89,  7'd84,  7'd79,  7'd74,  7'd69,  7'd64,  7'd59, 7'd53
    };

    state_t      state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic [31:0] x_q, x_d, y_q, y_d, out_y_q, out_y_d, a_q, a_d, b_q, b_d;
    logic        out_inv_q, out_inv_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  seed_e;
    logic [6:0]  seed_m;
    logic [31:0] seed;

    // Biased exponent halves as (e+127)>>1; an even biased exponent means an odd true one.
    assign seed_e = 8'({1'b0, x_q[30:24]}) + 8'd63 + {7'b0, x_q[23]};
    assign seed_m = x_q[23] ? EVEN_TBL[x_q[22:19]] : ODD_TBL[x_q[22:19]];
    assign seed   = {1'b0, seed_e, seed_m, 16'b0};

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign fpu_req   = state_q == DIV_REQ || state_q == ADD_REQ || state_q == MUL_REQ;
    assign out_y     = out_y_q;
    assign out_inv   = out_inv_q;
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        x_d       = x_q;
        y_d       = y_q;
        out_y_d   = out_y_q;
        out_inv_d = out_inv_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = in_x;
                state_d = CLASS;
            end
            CLASS: begin
                state_d = DONE;
                if (x_q[30:23] == 8'd0) begin
                    out_y_d   = {x_q[31], 31'b0};
                    out_inv_d = 1'b0;
                end else if (x_q[31] || (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0)) begin
                    out_y_d   = QNAN;
                    out_inv_d = 1'b1;
                end else if (x_q[30:23] == 8'hFF) begin
                    out_y_d   = x_q;
                    out_inv_d = 1'b0;
                end else begin
                    iter_d  = 3'd0;
                    state_d = SEED;
                end
            end
            SEED: begin
                y_d     = seed;
                op_d    = OP_DIV;
                a_d     = x_q;
                b_d     = seed;
                state_d = DIV_REQ;
            end
            DIV_REQ: state_d = fpu_gnt ? DIV_WAIT : DIV_REQ;
            ADD_REQ: state_d = fpu_gnt ? ADD_WAIT : ADD_REQ;
            MUL_REQ: state_d = fpu_gnt ? MUL_WAIT : MUL_REQ;
            DIV_WAIT: if (fpu_done) begin
                op_d    = OP_ADD;
                a_d     = y_q;
                b_d     = fpu_res;
                state_d = ADD_REQ;
            end
            ADD_WAIT: if (fpu_done) begin
                op_d    = OP_MUL;
                a_d     = fpu_res;
                b_d     = HALF;
                state_d = MUL_REQ;
            end
            MUL_WAIT: if (fpu_done) begin
                y_d = fpu_res;
                if (iter_q == 3'(ITERS - 1)) begin
                    out_y_d   = fpu_res;
                    out_inv_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    iter_d  = iter_q + 3'd1;
                    op_d    = OP_DIV;
                    a_d     = x_q;
                    b_d     = fpu_res;
                    state_d = DIV_REQ;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            iter_q    <= 3'd0;
            x_q       <= 32'd0;
            y_q       <= 32'd0;
            out_y_q   <= 32'd0;
            out_inv_q <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            x_q       <= x_d;
            y_q       <= y_d;
            out_y_q   <= out_y_d;
            out_inv_q <= out_inv_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end
endmodule
